rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle core's combinational decoder with a state machine that sequences one unified memory port through fetch, execute, memory and write-back. The unified port uses a request/ready handshake, so waited or slow memories are supported, with a parametrised timeout trap. The block drives every datapath enable and mux select, and keeps a retired-instruction counter.

---
 rtl/rv32i_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - multi-cycle RV32I control FSM with unified memory port and timeout trap
module rv32i_multicycle_ctrl #(
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_W          = 32,
    parameter bit HALT_ON_EBREAK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [11:0]      imm12,
    input  logic             branch_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_mode,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_EXEC_R  = 4'd2,  S_EXEC_I  = 4'd3,
        S_ALU_WB   = 4'd4,  S_MEM_ADDR = 4'd5,  S_MEM_READ = 4'd6, S_MEM_WB  = 4'd7,
        S_MEM_WRITE = 4'd8, S_BRANCH   = 4'd9,  S_JAL     = 4'd10, S_JALR    = 4'd11,
        S_LUI      = 4'd12, S_AUIPC    = 4'd13, S_HALT    = 4'd14, S_TRAP    = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            cur_state, nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              req_state;
    logic              timed_out;
    logic              is_env;
    logic              unused_inputs;

    assign state         = cur_state;
    assign unused_inputs = funct7_5;

    assign req_state = (cur_state == S_FETCH) || (cur_state == S_MEM_READ) ||
                       (cur_state == S_MEM_WRITE);
    // A ready arriving on the limit cycle still completes the access.
    assign timed_out = (MEM_TIMEOUT != 0) && req_state && !mem_ready &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign is_env    = (opcode == OP_SYSTEM) && (funct3 == 3'd0) &&
                       ((imm12 == 12'd0) || (imm12 == 12'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (timed_out)      nxt_state = S_TRAP;
                else if (mem_ready) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:                nxt_state = S_EXEC_R;
                    OP_I:                nxt_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:   nxt_state = S_MEM_ADDR;
                    OP_BRANCH:           nxt_state = S_BRANCH;
                    OP_JAL:              nxt_state = S_JAL;
                    OP_JALR:             nxt_state = S_JALR;
                    OP_LUI:              nxt_state = S_LUI;
                    OP_AUIPC:            nxt_state = S_AUIPC;
                    OP_FENCE:            nxt_state = S_FETCH;
                    default: begin
                        if (is_env) nxt_state = HALT_ON_EBREAK ? S_HALT : S_FETCH;
                        else        nxt_state = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I:          nxt_state = S_ALU_WB;
            S_ALU_WB, S_MEM_WB:          nxt_state = S_FETCH;
            S_MEM_ADDR:                  nxt_state = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (timed_out)      nxt_state = S_TRAP;
                else if (mem_ready) nxt_state = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (timed_out)      nxt_state = S_TRAP;
                else if (mem_ready) nxt_state = S_FETCH;
            end
            S_BRANCH, S_LUI:             nxt_state = S_FETCH;
            S_JAL, S_JALR, S_AUIPC:      nxt_state = S_ALU_WB;
            default:                     nxt_state = cur_state;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd0;
        alu_mode  = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_b_sel = 2'd2;
                end
            end
            S_DECODE: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
                retire    = (opcode == OP_FENCE) || (is_env && !HALT_ON_EBREAK);
            end
            S_EXEC_R: begin
                alu_a_sel = 2'd2;
                alu_mode  = 2'd2;
            end
            S_EXEC_I: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd1;
                alu_mode  = 2'd3;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                // Jumps write the return address old PC + 4 computed here.
                if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                end
            end
            S_MEM_ADDR: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd1;
            end
            S_MEM_READ: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                retire    = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                retire   = mem_ready;
            end
            S_BRANCH: begin
                alu_a_sel = 2'd2;
                alu_mode  = 2'd1;
                pc_write  = branch_cond;
                pc_src    = branch_cond;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd1;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                retire    = 1'b1;
            end
            S_AUIPC: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            instret    <= '0;
            halted     <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if (req_state && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
            if (nxt_state == S_HALT)
                halted <= 1'b1;
            if ((cur_state != S_TRAP) && (nxt_state == S_TRAP))
                trap_cause <= timed_out ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - self-checking bench for rv32i_multicycle_ctrl
module tb_rv32i_multicycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_ALU_WB = 4;
    localparam int S_MEM_ADDR = 5, S_MEM_READ = 6, S_MEM_WB = 7, S_MEM_WRITE = 8;
    localparam int S_BRANCH = 9, S_JAL = 10, S_JALR = 11, S_LUI = 12, S_AUIPC = 13;
    localparam int S_HALT = 14, S_TRAP = 15;
    localparam int A_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h13;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic [11:0] imm12 = 12'd0;
    logic        branch_cond = 1'b0;
    logic        mem_ready = 1'b0;

    logic        a_mem_req, a_mem_we, a_addr_sel, a_ir_write, a_pc_write, a_pc_src;
    logic [1:0]  a_alu_a_sel, a_alu_b_sel, a_alu_mode, a_wb_sel, a_trap_cause;
    logic        a_reg_write, a_retire, a_halted;
    logic [2:0]  a_instret;
    logic [3:0]  a_state;

    logic        b_mem_req, b_mem_we, b_addr_sel, b_ir_write, b_pc_write, b_pc_src;
    logic [1:0]  b_alu_a_sel, b_alu_b_sel, b_alu_mode, b_wb_sel, b_trap_cause;
    logic        b_reg_write, b_retire, b_halted;
    logic [31:0] b_instret;
    logic [3:0]  b_state;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    bit use_b = 1'b0;

    rv32i_multicycle_ctrl #(.MEM_TIMEOUT(A_TIMEOUT), .CNT_W(3), .HALT_ON_EBREAK(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .imm12(imm12), .branch_cond(branch_cond), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .addr_sel(a_addr_sel), .ir_write(a_ir_write),
        .pc_write(a_pc_write), .pc_src(a_pc_src), .alu_a_sel(a_alu_a_sel), .alu_b_sel(a_alu_b_sel),
        .alu_mode(a_alu_mode), .reg_write(a_reg_write), .wb_sel(a_wb_sel), .retire(a_retire),
        .instret(a_instret), .halted(a_halted), .trap_cause(a_trap_cause), .state(a_state)
    );

    rv32i_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32), .HALT_ON_EBREAK(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .imm12(imm12), .branch_cond(branch_cond), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .addr_sel(b_addr_sel), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .pc_src(b_pc_src), .alu_a_sel(b_alu_a_sel), .alu_b_sel(b_alu_b_sel),
        .alu_mode(b_alu_mode), .reg_write(b_reg_write), .wb_sel(b_wb_sel), .retire(b_retire),
        .instret(b_instret), .halted(b_halted), .trap_cause(b_trap_cause), .state(b_state)
    );

    // The scenario engine observes whichever configuration is under test.
    wire [3:0]  s_state     = use_b ? b_state     : a_state;
    wire        s_mem_req   = use_b ? b_mem_req   : a_mem_req;
    wire        s_mem_we    = use_b ? b_mem_we    : a_mem_we;
    wire        s_addr_sel  = use_b ? b_addr_sel  : a_addr_sel;
    wire        s_ir_write  = use_b ? b_ir_write  : a_ir_write;
    wire        s_pc_write  = use_b ? b_pc_write  : a_pc_write;
    wire        s_pc_src    = use_b ? b_pc_src    : a_pc_src;
    wire [1:0]  s_alu_a_sel = use_b ? b_alu_a_sel : a_alu_a_sel;
    wire [1:0]  s_alu_b_sel = use_b ? b_alu_b_sel : a_alu_b_sel;
    wire        s_reg_write = use_b ? b_reg_write : a_reg_write;
    wire [1:0]  s_wb_sel    = use_b ? b_wb_sel    : a_wb_sel;
    wire        s_retire    = use_b ? b_retire    : a_retire;
    wire [31:0] s_instret   = use_b ? b_instret   : {29'd0, a_instret};
    wire [31:0] cnt_mask    = use_b ? 32'hFFFF_FFFF : 32'h7;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        model_cnt = 0;
    endtask

    // Runs one instruction from its first FETCH cycle; wf/wm are wait cycles on fetch/data access.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm,
                             input logic bc, input int wf, input int wm);
        int path[$];
        int n;
        path = {};
        for (int k = 0; k <= wf; k++) path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            7'h33: begin path.push_back(S_EXEC_R); path.push_back(S_ALU_WB); end
            7'h13: begin path.push_back(S_EXEC_I); path.push_back(S_ALU_WB); end
            7'h03: begin
                path.push_back(S_MEM_ADDR);
                for (int k = 0; k <= wm; k++) path.push_back(S_MEM_READ);
                path.push_back(S_MEM_WB);
            end
            7'h23: begin
                path.push_back(S_MEM_ADDR);
                for (int k = 0; k <= wm; k++) path.push_back(S_MEM_WRITE);
            end
            7'h63: path.push_back(S_BRANCH);
            7'h6F: begin path.push_back(S_JAL); path.push_back(S_ALU_WB); end
            7'h67: begin path.push_back(S_JALR); path.push_back(S_ALU_WB); end
            7'h37: path.push_back(S_LUI);
            7'h17: begin path.push_back(S_AUIPC); path.push_back(S_ALU_WB); end
            default: ;
        endcase
        opcode = op; funct3 = f3; imm12 = imm; branch_cond = bc; funct7_5 = 1'($urandom);
        n = path.size();
        for (int i = 0; i < n; i++) begin
            bit is_mem, last_grp, e_pcw, e_pcs, e_rw;
            int e_wb;
            is_mem   = (path[i] == S_FETCH) || (path[i] == S_MEM_READ) || (path[i] == S_MEM_WRITE);
            last_grp = (i == n - 1);
            if (i < n - 1) last_grp = (path[i + 1] != path[i]);
            mem_ready = is_mem ? last_grp : 1'($urandom);
            e_pcw = (path[i] == S_FETCH && last_grp) || (path[i] == S_BRANCH && bc) ||
                    (path[i] == S_JAL) || (path[i] == S_JALR);
            e_pcs = (path[i] == S_BRANCH) && bc;
            e_rw  = (path[i] == S_ALU_WB) || (path[i] == S_MEM_WB) || (path[i] == S_LUI);
            e_wb  = (path[i] == S_MEM_WB) ? 1 : (path[i] == S_LUI) ? 2 : 0;
            #1;
            checks++;
            if (s_state !== 4'(path[i])) begin
                errors++;
                $display("FAIL state op=%h cyc=%0d: got %0d want %0d", op, i, s_state, path[i]);
            end
            checks++;
            if (s_retire !== (i == n - 1)) begin
                errors++;
                $display("FAIL retire op=%h cyc=%0d: got %0b want %0b", op, i, s_retire, (i == n - 1));
            end
            checks++;
            if ({s_mem_req, s_addr_sel, s_mem_we} !==
                {is_mem, is_mem && path[i] != S_FETCH, path[i] == S_MEM_WRITE}) begin
                errors++;
                $display("FAIL memport op=%h cyc=%0d: req/addr/we got %b%b%b", op, i,
                         s_mem_req, s_addr_sel, s_mem_we);
            end
            checks++;
            if ({s_pc_write, s_pc_src, s_reg_write, s_wb_sel, s_ir_write} !==
                {e_pcw, e_pcs, e_rw, 2'(e_wb), path[i] == S_FETCH && last_grp}) begin
                errors++;
                $display("FAIL enables op=%h cyc=%0d: pcw/pcs/rw/wb/ir got %b%b%b%0d%b want %b%b%b%0d%b",
                         op, i, s_pc_write, s_pc_src, s_reg_write, s_wb_sel, s_ir_write,
                         e_pcw, e_pcs, e_rw, e_wb, path[i] == S_FETCH && last_grp);
            end
            if ((path[i] == S_ALU_WB && (op == 7'h6F || op == 7'h67)) ||
                (path[i] == S_FETCH && last_grp)) begin
                checks++;
                if ({s_alu_a_sel, s_alu_b_sel} !== {(path[i] == S_ALU_WB) ? 2'd1 : 2'd0, 2'd2}) begin
                    errors++;
                    $display("FAIL alu_sel op=%h cyc=%0d: a=%0d b=%0d", op, i, s_alu_a_sel, s_alu_b_sel);
                end
            end
            tick();
        end
        model_cnt++;
        checks++;
        if (s_instret !== (32'(model_cnt) & cnt_mask)) begin
            errors++;
            $display("FAIL instret op=%h: got %0d want %0d", op, s_instret, 32'(model_cnt) & cnt_mask);
        end
        checks++;
        if (s_state !== 4'(S_FETCH)) begin
            errors++;
            $display("FAIL next_fetch op=%h: got %0d want %0d", op, s_state, S_FETCH);
        end
    endtask

    task automatic test_reset;
        use_b = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({a_state, b_state} !== 8'h00 || a_instret !== 3'd0 || b_instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: states=%h/%h instret=%0d/%0d want 0", a_state, b_state,
                     a_instret, b_instret);
        end
        checks++;
        if ({a_halted, b_halted, a_trap_cause, b_trap_cause} !== 6'd0) begin
            errors++;
            $display("FAIL reset_sticky: halted=%b%b trap=%0d/%0d want 0", a_halted, b_halted,
                     a_trap_cause, b_trap_cause);
        end
        checks++;
        if ({a_mem_req, b_mem_req, a_mem_we, a_addr_sel} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_fetch_req: req=%b%b we=%b addr=%b want req=11", a_mem_req, b_mem_req,
                     a_mem_we, a_addr_sel);
        end
        model_cnt = 0;
    endtask

    task automatic test_addi;
        use_b = 1'b0;
        do_reset();
        run_instr(7'h13, 3'd0, 12'd5, 1'b0, 0, 0);
    endtask

    task automatic test_load_waits;
        use_b = 1'b0;
        do_reset();
        run_instr(7'h03, 3'd2, 12'd8, 1'b0, 0, 3);
        run_instr(7'h23, 3'd2, 12'd8, 1'b0, 2, 1);
    endtask

    task automatic test_branch;
        use_b = 1'b0;
        do_reset();
        run_instr(7'h63, 3'd0, 12'd16, 1'b1, 0, 0);
        run_instr(7'h63, 3'd1, 12'd16, 1'b0, 0, 0);
    endtask

    task automatic test_timeout;
        int req_cycles;
        bit reached;
        use_b = 1'b0;
        do_reset();
        opcode = 7'h23; funct3 = 3'd2;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        req_cycles = 0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            #1;
            if (a_state == 4'(S_TRAP)) reached = 1'b1;
            else begin
                if (a_state == 4'(S_MEM_WRITE) && a_mem_req) req_cycles++;
                tick();
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL timeout_reach: state=%0d want %0d within budget", a_state, S_TRAP);
        end
        checks++;
        if (req_cycles !== A_TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len: request cycles=%0d want %0d", req_cycles, A_TIMEOUT + 1);
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            #1;
            checks++;
            if ({a_state, a_trap_cause, a_mem_req, a_retire, a_pc_write} !== {4'(S_TRAP), 2'd2, 3'b000}) begin
                errors++;
                $display("FAIL timeout_sticky: state=%0d cause=%0d req=%b ret=%b want 15/2/0/0",
                         a_state, a_trap_cause, a_mem_req, a_retire);
            end
            tick();
        end
        do_reset();
        #1;
        checks++;
        if (a_state !== 4'(S_FETCH) || a_trap_cause !== 2'd0) begin
            errors++;
            $display("FAIL trap_reset: state=%0d cause=%0d want 0/0", a_state, a_trap_cause);
        end
    endtask

    task automatic test_illegal;
        logic [6:0]  ops [3] = '{7'h7F, 7'h73, 7'h73};
        logic [2:0]  f3s [3] = '{3'd0, 3'd1, 3'd0};
        logic [11:0] imms[3] = '{12'd0, 12'd1, 12'd2};
        use_b = 1'b0;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            opcode = ops[t]; funct3 = f3s[t]; imm12 = imms[t];
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            #1;
            checks++;
            if (a_retire !== 1'b0) begin
                errors++;
                $display("FAIL illegal_retire t=%0d: got %b want 0", t, a_retire);
            end
            tick();
            checks++;
            if ({a_state, a_trap_cause, a_mem_req, a_halted} !== {4'(S_TRAP), 2'd1, 2'b00}) begin
                errors++;
                $display("FAIL illegal_trap t=%0d: state=%0d cause=%0d req=%b want 15/1/0",
                         t, a_state, a_trap_cause, a_mem_req);
            end
        end
    endtask

    task automatic test_ebreak;
        use_b = 1'b0;
        do_reset();
        opcode = 7'h73; funct3 = 3'd0; imm12 = 12'd1;
        mem_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (a_retire !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_retire: got %b want 0", a_retire);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom);
            #1;
            checks++;
            if ({a_state, a_halted, a_mem_req, a_retire, a_trap_cause} !== {4'(S_HALT), 3'b100, 2'd0}) begin
                errors++;
                $display("FAIL ebreak_halt: state=%0d halted=%b req=%b want 14/1/0", a_state,
                         a_halted, a_mem_req);
            end
            checks++;
            if (a_instret !== 3'd0) begin
                errors++;
                $display("FAIL ebreak_instret: got %0d want 0", a_instret);
            end
            tick();
        end
        use_b = 1'b1;
        do_reset();
        run_instr(7'h73, 3'd0, 12'd1, 1'b0, 0, 0);
        run_instr(7'h73, 3'd0, 12'd0, 1'b0, 1, 0);
        run_instr(7'h0F, 3'd0, 12'd0, 1'b0, 0, 0);
        checks++;
        if (b_halted !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_nop_halted: got %b want 0", b_halted);
        end
    endtask

    task automatic test_wrap;
        use_b = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) run_instr(7'h37, 3'($urandom), 12'($urandom), 1'b0, 0, 0);
        checks++;
        if (a_instret !== 3'd0) begin
            errors++;
            $display("FAIL wrap: instret=%0d want 0", a_instret);
        end
    endtask

    task automatic test_reset_mid;
        use_b = 1'b0;
        do_reset();
        run_instr(7'h13, 3'd0, 12'd1, 1'b0, 0, 0);
        opcode = 7'h03;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        checks++;
        if (a_state !== 4'(S_MEM_READ) || a_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: state=%0d req=%b want 6/1", a_state, a_mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_cnt = 0;
        #1;
        checks++;
        if (a_state !== 4'(S_FETCH) || a_instret !== 3'd0 || a_addr_sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d instret=%0d addr=%b want 0/0/0", a_state,
                     a_instret, a_addr_sel);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
        for (int d = 0; d < 2; d++) begin
            use_b = (d == 1);
            do_reset();
            for (int i = 0; i < 30; i++) begin
                run_instr(ops[$urandom_range(0, 9)], 3'($urandom), 12'($urandom), 1'($urandom),
                          $urandom_range(0, A_TIMEOUT), $urandom_range(0, A_TIMEOUT));
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_waits();
        test_branch();
        test_timeout();
        test_illegal();
        test_ebreak();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
